// File: rtl/latch_bank_ctrl_pkg.sv
// Shared types and width helpers for the latch bank write controller.
// FSM state encoding plus address and pulse-counter width functions.
package latch_bank_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSetup = 2'd1,
        StOpen  = 2'd2,
        StHold  = 2'd3
    } state_e;

    // Never return zero so a one-entry or one-cycle configuration still gets a 1-bit field.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned addr_width(input int unsigned depth);
        return clog2_min1(depth);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned pulse_cyc);
        return clog2_min1(pulse_cyc);
    endfunction

endpackage

// File: rtl/latch_bank_ctrl_if.sv
// Requester/latch-array bundle for the latch bank write controller.
// master = requesting side (and observer), slave = controller.
interface latch_bank_ctrl_if
    import latch_bank_ctrl_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned AW = addr_width(DEPTH);

    logic [NREQ-1:0]       req;
    logic [NREQ*AW-1:0]    req_addr;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic                  err;
    logic [DEPTH-1:0]      lat_en;
    logic [WIDTH-1:0]      lat_d;
    logic                  busy;

    modport master (
        output req, req_addr, req_data,
        input  gnt, ack, err, lat_en, lat_d, busy
    );

    modport slave (
        input  req, req_addr, req_data,
        output gnt, ack, err, lat_en, lat_d, busy
    );

endinterface

// File: rtl/latch_bank_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: scans from ptr upward, skipping masked requesters.
// Produces a one-hot grant, the winner index and a valid flag.
module latch_bank_ctrl_rr_arbiter
    import latch_bank_ctrl_pkg::*;
#(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IW   = clog2_min1(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] inel,
    input  logic [IW-1:0]   ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            valid
);

    always_comb begin
        int unsigned j;
        j     = 0;
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            j = (32'(ptr) + k) % NREQ;
            if (en && !valid && req[j] && !inel[j]) begin
                valid  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/latch_bank_ctrl.sv
// Write controller for a bank of level-sensitive latches: arbitrates requesters and
// sequences each write as setup -> enable pulse -> hold, with registered outputs.
module latch_bank_ctrl
    import latch_bank_ctrl_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned PULSE_CYC = 2
) (
    input logic              clk,
    input logic              rst_n,
    latch_bank_ctrl_if.slave bus
);

    localparam int unsigned AW = addr_width(DEPTH);
    localparam int unsigned CW = cnt_width(PULSE_CYC);
    localparam int unsigned IW = clog2_min1(NREQ);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [IW-1:0]    rr_q, rr_d;
    logic [NREQ-1:0]  inel_q, inel_d;

    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [NREQ-1:0]  ack_q, ack_d;
    logic             err_q, err_d;
    logic [DEPTH-1:0] lat_en_q, lat_en_d;
    logic [WIDTH-1:0] lat_d_q, lat_d_d;
    logic             busy_q, busy_d;

    logic [NREQ-1:0]  arb_gnt;
    logic [IW-1:0]    arb_idx;
    logic             arb_valid;
    logic [DEPTH-1:0] addr_dec;
    logic             in_range;

    latch_bank_ctrl_rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req   (bus.req),
        .inel  (inel_q),
        .ptr   (rr_q),
        .en    (state_q == StIdle),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    // An address with no matching entry decodes to all-zero, which doubles as the range check.
    always_comb begin
        addr_dec = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (addr_q == AW'(i)) addr_dec[i] = 1'b1;
        end
    end

    assign in_range = |addr_dec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            rr_q     <= '0;
            inel_q   <= '0;
            gnt_q    <= '0;
            ack_q    <= '0;
            err_q    <= 1'b0;
            lat_en_q <= '0;
            lat_d_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            rr_q     <= rr_d;
            inel_q   <= inel_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            lat_en_q <= lat_en_d;
            lat_d_q  <= lat_d_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rr_d    = rr_q;
        // The requester finishing in HOLD sits out the first IDLE cycle.
        inel_d  = (state_q == StHold) ? gnt_q : '0;
        unique case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    state_d = StSetup;
                    addr_d  = bus.req_addr[32'(arb_idx)*AW +: AW];
                    data_d  = bus.req_data[32'(arb_idx)*WIDTH +: WIDTH];
                    rr_d    = (32'(arb_idx) == NREQ - 1) ? '0 : arb_idx + IW'(1);
                end
            end
            StSetup: begin
                if (in_range) begin
                    state_d = StOpen;
                    cnt_d   = CW'(PULSE_CYC - 1);
                end else begin
                    state_d = StHold;
                end
            end
            StOpen: begin
                if (cnt_q == '0) state_d = StHold;
                else             cnt_d   = cnt_q - CW'(1);
            end
            StHold:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_comb begin
        gnt_d = '0;
        if (state_q == StIdle) begin
            if (arb_valid) gnt_d = arb_gnt;
        end else if (state_d != StIdle) begin
            gnt_d = gnt_q;
        end
        ack_d    = (state_d == StHold) ? gnt_q : '0;
        err_d    = (state_d == StHold) && !in_range;
        lat_en_d = (state_d == StOpen) ? addr_dec : '0;
        lat_d_d  = (state_d != StIdle) ? data_d : lat_d_q;
        busy_d   = (state_d != StIdle);
    end

    assign bus.gnt    = gnt_q;
    assign bus.ack    = ack_q;
    assign bus.err    = err_q;
    assign bus.lat_en = lat_en_q;
    assign bus.lat_d  = lat_d_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_latch_bank_ctrl.sv
// Directed bench for latch_bank_ctrl: an 8-entry instance with a write scoreboard and a
// 6-entry instance for the out-of-range path.
module tb_latch_bank_ctrl;

    typedef struct {
        int         idx;
        int         addr;
        logic [7:0] data;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    exp_t q8[$];

    latch_bank_ctrl_if #(.NREQ(4), .DEPTH(8), .WIDTH(8)) bus8 ();
    latch_bank_ctrl_if #(.NREQ(4), .DEPTH(6), .WIDTH(8)) bus6 ();

    latch_bank_ctrl #(.NREQ(4), .DEPTH(8), .WIDTH(8), .PULSE_CYC(2)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    latch_bank_ctrl #(.NREQ(4), .DEPTH(6), .WIDTH(8), .PULSE_CYC(2)) dut6 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req8(input int i, input int addr, input logic [7:0] data);
        bus8.req_addr[i*3 +: 3] = 3'(addr);
        bus8.req_data[i*8 +: 8] = data;
        bus8.req[i]             = 1'b1;
    endtask

    // One clock, sampled 1ns after the rising edge, with per-cycle scoreboard checks.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        chk("gnt_onehot8", 64'($countones(bus8.gnt) <= 1), 64'd1);
        chk("err_never8", bus8.err, 0);
        if (bus8.lat_en != '0) begin
            if (q8.size() == 0) begin
                chk("lat_en_unexpected8", bus8.lat_en, 0);
            end else begin
                chk("lat_en_addr8", bus8.lat_en, 64'd1 << q8[0].addr);
                chk("lat_d_open8", bus8.lat_d, q8[0].data);
            end
        end
        if (bus8.ack != '0) begin
            if (q8.size() == 0) begin
                chk("ack_unexpected8", bus8.ack, 0);
            end else begin
                e = q8.pop_front();
                chk("ack_idx8", bus8.ack, 64'd1 << e.idx);
                chk("lat_d_hold8", bus8.lat_d, e.data);
            end
        end
        chk("lat_en_never6", bus6.lat_en, 0);
        chk("err_with_ack6", bus6.err, |bus6.ack);
    endtask

    initial begin
        int ack_edge;
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        bus8.req      = '0;
        bus8.req_addr = '0;
        bus8.req_data = '0;
        bus6.req      = '0;
        bus6.req_addr = '0;
        bus6.req_data = '0;

        // Reset state
        step();
        step();
        chk("rst_gnt", bus8.gnt, 0);
        chk("rst_ack", bus8.ack, 0);
        chk("rst_err", bus8.err, 0);
        chk("rst_lat_en", bus8.lat_en, 0);
        chk("rst_lat_d", bus8.lat_d, 0);
        chk("rst_busy", bus8.busy, 0);
        rst_n = 1'b1;
        step();

        // Single write: req[1] asserted just after edge 0
        set_req8(1, 3, 8'hA5);
        q8.push_back('{1, 3, 8'hA5});
        step();
        chk("single_gnt_e1", bus8.gnt, 4'b0010);
        chk("single_lat_en_e1", bus8.lat_en, 0);
        chk("single_busy_e1", bus8.busy, 1);
        step();
        chk("single_lat_en_e2", bus8.lat_en, 8'h08);
        chk("single_lat_d_e2", bus8.lat_d, 8'hA5);
        step();
        chk("single_lat_en_e3", bus8.lat_en, 8'h08);
        chk("single_lat_d_e3", bus8.lat_d, 8'hA5);
        step();
        chk("single_ack_e4", bus8.ack, 4'b0010);
        chk("single_lat_en_e4", bus8.lat_en, 0);
        bus8.req = '0;
        step();
        step();
        chk("single_idle_busy", bus8.busy, 0);
        chk("single_lat_d_kept", bus8.lat_d, 8'hA5);

        // Reset in the middle of the enable pulse
        set_req8(1, 2, 8'h77);
        q8.push_back('{1, 2, 8'h77});
        step();
        step();
        chk("rst_mid_open_lat_en", bus8.lat_en, 8'h04);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_lat_en_drop", bus8.lat_en, 0);
        chk("rst_mid_gnt", bus8.gnt, 0);
        chk("rst_mid_busy", bus8.busy, 0);
        q8.delete();
        bus8.req = '0;
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("rst_rel_ack", bus8.ack, 0);
        chk("rst_rel_lat_d", bus8.lat_d, 0);
        chk("rst_rel_busy", bus8.busy, 0);
        chk("rst_rel_gnt", bus8.gnt, 0);

        // All four requesting: order 0,1,2,3,0
        for (int i = 0; i < 4; i++) set_req8(i, i + 4, 8'(8'h10 + i));
        for (int i = 0; i < 5; i++) q8.push_back('{i % 4, (i % 4) + 4, 8'(8'h10 + (i % 4))});
        for (int c = 0; c < 60; c++) begin
            step();
            if (q8.size() == 0) begin
                bus8.req = '0;
                break;
            end
        end
        chk("rr_all_served", 64'(q8.size()), 0);
        q8.delete();
        step();
        step();

        // Requester drops req and changes data after capture
        set_req8(2, 5, 8'h3C);
        q8.push_back('{2, 5, 8'h3C});
        step();
        chk("drop_gnt_e1", bus8.gnt, 4'b0100);
        step();
        bus8.req[2]             = 1'b0;
        bus8.req_data[2*8 +: 8] = 8'hFF;
        bus8.req_addr[2*3 +: 3] = 3'd1;
        step();
        chk("drop_lat_d_e3", bus8.lat_d, 8'h3C);
        step();
        chk("drop_ack_e4", bus8.ack, 4'b0100);
        step();
        step();

        // req[0] held after its ack while req[3] waits: 0, then 3, then 0
        set_req8(0, 2, 8'h5A);
        q8.push_back('{0, 2, 8'h5A});
        step();
        chk("fair_first_gnt", bus8.gnt, 4'b0001);
        set_req8(3, 6, 8'hC3);
        q8.push_back('{3, 6, 8'hC3});
        q8.push_back('{0, 2, 8'h5A});
        for (int c = 0; c < 60; c++) begin
            step();
            if (bus8.ack[3]) bus8.req[3] = 1'b0;
            if (q8.size() == 0) begin
                bus8.req = '0;
                break;
            end
        end
        chk("fair_all_served", 64'(q8.size()), 0);
        q8.delete();
        step();
        step();
        chk("fair_idle_busy", bus8.busy, 0);

        // Out-of-range address on the 6-entry bank
        bus6.req_addr[2:0] = 3'd7;
        bus6.req_data[7:0] = 8'h55;
        bus6.req[0]        = 1'b1;
        ack_edge = 0;
        for (int e = 1; e <= 6; e++) begin
            step();
            if (bus6.ack != '0 && ack_edge == 0) begin
                ack_edge = e;
                chk("oor_ack", bus6.ack, 4'b0001);
                chk("oor_err", bus6.err, 1);
                bus6.req = '0;
            end
        end
        chk("oor_ack_seen", 64'(ack_edge != 0), 1);
        chk("oor_ack_by_e3", 64'(ack_edge <= 3), 1);
        chk("oor_idle_busy", bus6.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
